// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU memory types: word, RAM state and arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  // Data wins unless instruction fetch has been starved for the maximum count.
  function automatic arb_state_t pick_owner(input logic i_req, input logic d_req,
                                            input logic starved);
    if (d_req && !(starved && i_req)) return DGNT;
    else if (i_req) return IGNT;
    return IDLE;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data arbiter for a single-ported RAM.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t    state, next_state;
  logic [SW-1:0] starve_cnt, starve_next;
  ramstate_t     rs;
  logic          d_req, ram_done, done;

  always_comb begin
    rs          = ramstate_t'(ramstate);
    d_req       = dREN | dWEN;
    ram_done    = (rs == ACCESS) || (rs == ERROR);
    done        = 1'b0;
    next_state  = state;
    starve_next = iREN ? starve_cnt : '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iwait       = iREN;
    dwait       = d_req;
    iload       = '0;
    dload       = '0;

    case (state)
      IDLE: next_state = pick_owner(iREN, d_req, starve_cnt == STARVE_LIM);
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          next_state = IDLE;
        end else if (ram_done) begin
          done        = 1'b1;
          iwait       = 1'b0;
          iload       = (rs == ACCESS) ? ramload : '0;
          starve_next = '0;
          next_state  = pick_owner(iREN, d_req, 1'b0);
        end
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          next_state = IDLE;
        end else if (ram_done) begin
          done  = 1'b1;
          dwait = 1'b0;
          dload = (rs == ACCESS) ? ramload : '0;
          // Back-to-back arbitration must see the count this completion produces.
          if (iREN && starve_cnt != STARVE_LIM) starve_next = starve_cnt + 1'b1;
          next_state = pick_owner(iREN, d_req, starve_next == STARVE_LIM);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_next;
      if (done && rs == ERROR) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1;
    repeat (2) @(posedge CLK);
    #1 nRST = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    iREN = 1;
    nRST = 1;
    #2;
    total++;
    if ({ramREN, ramWEN, iwait, dwait, err} !== 5'b00100) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=00100", {ramREN, ramWEN, iwait, dwait, err});
    end
    total++;
    if ({ramaddr, ramstore, iload, dload} !== 128'h0) begin
      bad++;
      $display("FAIL reset_data got=%h %h %h %h want=0", ramaddr, ramstore, iload, dload);
    end
    dREN = 1;
    #1;
    total++;
    if (dwait !== 1'b1) begin bad++; $display("FAIL reset_dwait got=%b want=1", dwait); end
    tick();
    nRST = 0;
    idle_inputs();
  endtask

  task automatic test_instr_fetch();
    do_reset();
    iREN = 1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'hFFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin ramstate = ACCESS; ramload = 32'h2402000A; end
      #3;
      total++;
      if (ramREN !== (c > 0)) begin bad++; $display("FAIL fetch_ramREN c=%0d got=%b", c, ramREN); end
      total++;
      if (iwait !== (c != 3)) begin bad++; $display("FAIL fetch_iwait c=%0d got=%b", c, iwait); end
      total++;
      if (iload !== (c == 3 ? 32'h2402000A : 32'h0))
        begin bad++; $display("FAIL fetch_iload c=%0d got=%h", c, iload); end
      if (c > 0) begin
        total++;
        if (ramaddr !== 32'h40) begin bad++; $display("FAIL fetch_addr got=%h want=40", ramaddr); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h100; ramstate = BUSY;
    #3;
    total++;
    if (ramREN !== 1'b0) begin bad++; $display("FAIL sim_nocomb got=%b want=0", ramREN); end
    tick();
    #3;
    total++;
    if ({ramREN, iwait, dwait, ramaddr} !== {3'b111, 32'h100})
      begin bad++; $display("FAIL sim_dfirst got=%b%b%b %h", ramREN, iwait, dwait, ramaddr); end
    tick();
    ramstate = ACCESS;
    for (int c = 2; c < 6; c++) begin
      ramload = 32'h1000 + c;
      #3;
      total++;
      if ({dwait, iwait, dload} !== {2'b01, 32'h1000 + c})
        begin bad++; $display("FAIL sim_dcomp c=%0d got=%b%b %h", c, dwait, iwait, dload); end
      tick();
    end
    #3;
    total++;
    if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h200})
      begin bad++; $display("FAIL sim_ignt got=%b%b %h want=10 200", ramREN, ramWEN, ramaddr); end
    tick();
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic [3:0] want;
    do_reset();
    iREN = 1; dWEN = 1; iaddr = 32'h400; daddr = 32'h300; dstore = 32'hCAFE; ramstate = ACCESS;
    tick();
    for (int c = 1; c < 7; c++) begin
      #3;
      want = (c == 5) ? 4'b0110 : 4'b1001;
      total++;
      if ({ramWEN, ramREN, dwait, iwait} !== want)
        begin bad++; $display("FAIL starve_seq c=%0d got=%b want=%b", c, {ramWEN, ramREN, dwait, iwait}, want); end
      if (c >= 5) begin
        total++;
        if (int'(dut.starve_cnt) !== (c == 5 ? 4 : 0))
          begin bad++; $display("FAIL starve_cnt c=%0d got=%0d", c, dut.starve_cnt); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    dREN = 1; daddr = 32'h88; ramstate = BUSY;
    tick();
    #3;
    total++;
    if ({ramREN, dwait} !== 2'b11) begin bad++; $display("FAIL abort_grant got=%b%b want=11", ramREN, dwait); end
    tick();
    dREN = 0;
    #3;
    total++;
    if ({ramREN, dwait} !== 2'b00) begin bad++; $display("FAIL abort_drop got=%b%b want=00", ramREN, dwait); end
    tick();
    dREN = 1;
    #3;
    total++;
    if (ramREN !== 1'b0 || dut.state !== IDLE)
      begin bad++; $display("FAIL abort_idle ramREN=%b state=%0d want 0 IDLE", ramREN, dut.state); end
    tick();
    idle_inputs();
  endtask

  task automatic test_error();
    do_reset();
    dREN = 1; daddr = 32'h44; ramstate = BUSY;
    tick();
    ramstate = ERROR; ramload = 32'hDEAD_BEEF;
    #3;
    total++;
    if ({dwait, err, dload} !== {2'b00, 32'h0})
      begin bad++; $display("FAIL err_cycle got=%b%b %h want=00 0", dwait, err, dload); end
    tick();
    dREN = 0; ramstate = FREE;
    #3;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", err); end
    repeat (3) tick();
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
    nRST = 1;
    #1;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", err); end
    tick();
    nRST = 0;
  endtask

  task automatic test_reset_midgrant();
    do_reset();
    iREN = 1; iaddr = 32'h80; ramstate = BUSY;
    tick();
    #2;
    total++;
    if (ramREN !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b want=1", ramREN); end
    nRST = 1; ramstate = ACCESS; ramload = 32'h99;
    #1;
    total++;
    if ({ramREN, ramWEN, iwait, err, ramaddr, iload} !== {4'b0010, 64'h0})
      begin bad++; $display("FAIL midrst_out got=%b%b%b%b %h %h", ramREN, ramWEN, iwait, err, ramaddr, iload); end
    total++;
    if (dut.state !== IDLE || int'(dut.starve_cnt) !== 0)
      begin bad++; $display("FAIL midrst_state state=%0d cnt=%0d", dut.state, dut.starve_cnt); end
    tick();
    nRST = 0;
    idle_inputs();
  endtask

  task automatic test_random();
    int owner, starve;
    bit merr, dreq, oreq, fin;
    logic [4:0]  e_ctl;
    logic [63:0] e_addr, e_load;
    do_reset();
    owner = 0; starve = 0; merr = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) iREN = ~iREN;
      if ($urandom_range(0, 4) == 0) dREN = ~dREN;
      if ($urandom_range(0, 6) == 0) dWEN = ~dWEN;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      #3;
      dreq = dREN | dWEN;
      oreq = (owner == 1) ? iREN : (owner == 2) ? dreq : 1'b0;
      fin  = (owner != 0) && oreq && (ramstate >= 2);
      e_ctl[4] = (owner == 1) ? iREN : (owner == 2) ? (dREN & ~dWEN) : 1'b0;
      e_ctl[3] = (owner == 2) ? dWEN : 1'b0;
      e_ctl[2] = (fin && owner == 1) ? 1'b0 : iREN;
      e_ctl[1] = (fin && owner == 2) ? 1'b0 : dreq;
      e_ctl[0] = merr;
      e_addr = {(owner == 1) ? iaddr : (owner == 2) ? daddr : 32'h0, (owner == 2) ? dstore : 32'h0};
      e_load = {(fin && owner == 1 && ramstate == 2) ? ramload : 32'h0,
                (fin && owner == 2 && ramstate == 2) ? ramload : 32'h0};
      total++;
      if ({ramREN, ramWEN, iwait, dwait, err} !== e_ctl)
        begin bad++; $display("FAIL rand_ctl n=%0d got=%b want=%b", n, {ramREN, ramWEN, iwait, dwait, err}, e_ctl); end
      total++;
      if ({ramaddr, ramstore} !== e_addr)
        begin bad++; $display("FAIL rand_addr n=%0d got=%h %h want=%h", n, ramaddr, ramstore, e_addr); end
      total++;
      if ({iload, dload} !== e_load)
        begin bad++; $display("FAIL rand_load n=%0d got=%h %h want=%h", n, iload, dload, e_load); end
      total++;
      if (int'(dut.starve_cnt) !== starve)
        begin bad++; $display("FAIL rand_starve n=%0d got=%0d want=%0d", n, dut.starve_cnt, starve); end
      if (fin) begin
        if (ramstate == 3) merr = 1;
        if (owner == 1) starve = 0;
        else if (iREN) starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
      end
      if (!iREN) starve = 0;
      if (owner == 0 || fin) owner = (dreq && !(iREN && starve == SMAX)) ? 2 : (iREN ? 1 : 0);
      else if (!oreq) owner = 0;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    nRST = 1;
    test_reset();
    test_instr_fetch();
    test_simultaneous();
    test_starvation();
    test_abort();
    test_error();
    test_reset_midgrant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
